// File: rtl/prog_loader_if.sv
// Stream, memory-port and CPU-control bundle between a word source and prog_loader.
// The loader takes the slave side; whatever feeds the stream takes the master side.
interface prog_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        halt;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic [63:0] wdata_ext_2;
  logic        cpu_enable;
  logic        busy;
  logic        error;

  modport master (
    output in_valid, in_data, halt,
    input  in_ready, addr_ext, wen_ext, wdata_ext,
           addr_ext_2, wen_ext_2, wdata_ext_2, cpu_enable, busy, error
  );

  modport slave (
    input  in_valid, in_data, halt,
    output in_ready, addr_ext, wen_ext, wdata_ext,
           addr_ext_2, wen_ext_2, wdata_ext_2, cpu_enable, busy, error
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time loader: decodes a 32-bit header/payload stream into instruction and
// data memory writes, then owns the CPU enable from START until halt.
module prog_loader #(
  parameter int CNT_W  = 16,
  parameter int BASE_W = 14
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);

  localparam int SUM_W = ((BASE_W > CNT_W) ? BASE_W : CNT_W) + 1;

  typedef enum logic [2:0] {
    S_HDR,
    S_IMEM,
    S_DLO,
    S_DHI,
    S_RUN,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_count;
  logic [BASE_W-1:0] r_base;
  logic [31:0]       r_low;
  logic [63:0]       r_addr;
  logic              r_wen;
  logic [31:0]       r_wdata;
  logic [63:0]       r_addr_2;
  logic              r_wen_2;
  logic [63:0]       r_wdata_2;

  logic              w_ready;
  logic              w_acc;
  logic              w_last;
  logic [1:0]        w_cmd;
  logic [CNT_W-1:0]  w_hdr_count;
  logic [SUM_W-1:0]  w_sum;

  assign w_ready     = (r_state == S_HDR) || (r_state == S_IMEM) ||
                       (r_state == S_DLO) || (r_state == S_DHI);
  assign w_acc       = bus.in_valid && w_ready;
  assign w_last      = (r_idx == (r_count - CNT_W'(1)));
  assign w_cmd       = bus.in_data[31:30];
  assign w_hdr_count = CNT_W'(bus.in_data[15:0]);
  // Widened by one bit so base + idx never wraps before the byte shift.
  assign w_sum       = SUM_W'(r_base) + SUM_W'(r_idx);

  // NOTE: reset is sampled on the clock edge here, so it sits inside the
  // clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HDR;
    else     r_state <= w_next;
  end

  // NOTE: w_next is defaulted before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR: begin
        if (w_acc) begin
          case (w_cmd)
            2'b00:   w_next = (w_hdr_count != '0) ? S_IMEM : S_HDR;
            2'b01:   w_next = (w_hdr_count != '0) ? S_DLO  : S_HDR;
            2'b10:   w_next = S_RUN;
            default: w_next = S_ERR;
          endcase
        end
      end
      S_IMEM:  if (w_acc && w_last) w_next = S_HDR;
      S_DLO:   if (w_acc) w_next = S_DHI;
      S_DHI:   if (w_acc) w_next = w_last ? S_HDR : S_DLO;
      S_RUN:   if (bus.halt) w_next = S_HDR;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_count   <= '0;
      r_base    <= '0;
      r_low     <= '0;
      r_addr    <= '0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_addr_2  <= '0;
      r_wen_2   <= 1'b0;
      r_wdata_2 <= '0;
    end else begin
      r_wen   <= 1'b0;
      r_wen_2 <= 1'b0;
      if (w_acc) begin
        case (r_state)
          S_HDR: begin
            r_base  <= BASE_W'(bus.in_data[29:16]);
            r_count <= w_hdr_count;
            r_idx   <= '0;
          end
          S_IMEM: begin
            r_wen   <= 1'b1;
            r_addr  <= 64'(w_sum) << 2;
            r_wdata <= bus.in_data;
            r_idx   <= r_idx + CNT_W'(1);
          end
          S_DLO: r_low <= bus.in_data;
          S_DHI: begin
            r_wen_2   <= 1'b1;
            r_addr_2  <= 64'(w_sum) << 3;
            r_wdata_2 <= {bus.in_data, r_low};
            r_idx     <= r_idx + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.busy        = (r_state == S_IMEM) || (r_state == S_DLO) || (r_state == S_DHI);
  assign bus.cpu_enable  = (r_state == S_RUN);
  assign bus.error       = (r_state == S_ERR);
  assign bus.addr_ext    = r_addr;
  assign bus.wen_ext     = r_wen;
  assign bus.wdata_ext   = r_wdata;
  assign bus.addr_ext_2  = r_addr_2;
  assign bus.wen_ext_2   = r_wen_2;
  assign bus.wdata_ext_2 = r_wdata_2;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed boot sequences plus randomized
// command streams with stalls, all compared against a behavioural loader model.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_loader_if bus ();

  prog_loader #(.CNT_W(16), .BASE_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the loader is doing, in words/commands, not states.
  typedef enum {M_IDLE, M_IMEM, M_DMEM, M_RUN, M_ERR} mode_t;
  mode_t       m_mode = M_IDLE;
  int          m_total;
  int          m_k;
  longint      m_base;
  bit          m_half;
  logic [31:0] m_low;
  bit          m_live = 1'b0;

  bit          e_wen, e_wen2, e_rdy, e_busy, e_en, e_err, e_rst;
  logic [63:0] e_addr, e_addr2, e_wd2;
  logic [31:0] e_wd;

  always @(posedge clk) begin : model
    bit acc;
    int cnt;
    if (rst) begin
      m_mode  = M_IDLE;
      e_wen   = 0; e_wen2 = 0;
      e_addr  = '0; e_wd = '0; e_addr2 = '0; e_wd2 = '0;
      e_rst   = 1;
      m_live  = 1;
    end else if (m_live) begin
      e_rst  = 0;
      e_wen  = 0;
      e_wen2 = 0;
      acc = bus.in_valid && (m_mode inside {M_IDLE, M_IMEM, M_DMEM});
      case (m_mode)
        M_IDLE: if (acc) begin
          cnt    = int'(bus.in_data[15:0]);
          m_base = longint'(bus.in_data[29:16]);
          m_k    = 0;
          m_half = 0;
          m_total = cnt;
          case (bus.in_data[31:30])
            2'b00:   if (cnt != 0) m_mode = M_IMEM;
            2'b01:   if (cnt != 0) m_mode = M_DMEM;
            2'b10:   m_mode = M_RUN;
            default: m_mode = M_ERR;
          endcase
        end
        M_IMEM: if (acc) begin
          e_wen  = 1;
          e_addr = 64'((m_base + longint'(m_k)) * 4);
          e_wd   = bus.in_data;
          m_k++;
          if (m_k == m_total) m_mode = M_IDLE;
        end
        M_DMEM: if (acc) begin
          if (!m_half) begin
            m_low  = bus.in_data;
            m_half = 1;
          end else begin
            e_wen2  = 1;
            e_addr2 = 64'((m_base + longint'(m_k)) * 8);
            e_wd2   = {bus.in_data, m_low};
            m_half  = 0;
            m_k++;
            if (m_k == m_total) m_mode = M_IDLE;
          end
        end
        M_RUN: if (bus.halt) m_mode = M_IDLE;
        default: ;
      endcase
    end
    e_rdy  = m_mode inside {M_IDLE, M_IMEM, M_DMEM};
    e_busy = m_mode inside {M_IMEM, M_DMEM};
    e_en   = (m_mode == M_RUN);
    e_err  = (m_mode == M_ERR);
  end

  typedef struct {
    int          cyc;
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;
  wr_t log1[$];
  wr_t log2[$];
  int  cyc = 0;

  // Per-cycle compare against the model, plus a write log for literal checks.
  always @(negedge clk) begin
    if (m_live) begin
      cyc++;
      check("in_ready",   bus.in_ready,   e_rdy);
      check("busy",       bus.busy,       e_busy);
      check("cpu_enable", bus.cpu_enable, e_en);
      check("error",      bus.error,      e_err);
      check("wen_ext",    bus.wen_ext,    e_wen);
      check("wen_ext_2",  bus.wen_ext_2,  e_wen2);
      if (e_wen || e_rst) begin
        check("addr_ext",  bus.addr_ext,  e_addr);
        check("wdata_ext", bus.wdata_ext, e_wd);
      end
      if (e_wen2 || e_rst) begin
        check("addr_ext_2",  bus.addr_ext_2,  e_addr2);
        check("wdata_ext_2", bus.wdata_ext_2, e_wd2);
      end
      if (bus.wen_ext === 1'b1)   log1.push_back('{cyc, bus.addr_ext, 64'(bus.wdata_ext)});
      if (bus.wen_ext_2 === 1'b1) log2.push_back('{cyc, bus.addr_ext_2, bus.wdata_ext_2});
    end
  end

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w, input bit stall);
    int t = 0;
    bit rdy;
    if (stall) begin
      int n = $urandom_range(0, 2);
      repeat (n) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.halt     = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus.halt = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    do begin
      rdy = bus.in_ready;
      @(negedge clk);
      t++;
    end while (!rdy && t < 64);
    if (!rdy) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: word 0x%0h not accepted after %0d cycles", w, t);
    end
  endtask

  int s1, s2;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.halt     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy",     bus.busy,     0);
    check("rst_enable",   bus.cpu_enable, 0);
    check("rst_error",    bus.error,    0);
    check("rst_addr",     bus.addr_ext, 0);
    rst = 1'b0;
    idle(2);

    // IMEM: base 2, three words back-to-back -> byte addresses 8, 12, 16
    s1 = log1.size();
    send(32'h0002_0003, 0);
    send(32'hAAAA_0001, 0);
    send(32'hBBBB_0002, 0);
    send(32'hCCCC_0003, 0);
    idle(3);
    #1;
    check("imem_count", 64'(log1.size() - s1), 3);
    if (log1.size() - s1 == 3) begin
      check("imem_a0", log1[s1].addr, 8);
      check("imem_a1", log1[s1+1].addr, 12);
      check("imem_a2", log1[s1+2].addr, 16);
      check("imem_d0", log1[s1].data, 64'hAAAA_0001);
      check("imem_d2", log1[s1+2].data, 64'hCCCC_0003);
      check("imem_b2b", 64'(log1[s1+2].cyc - log1[s1].cyc), 2);
    end
    check("imem_busy_done", bus.busy, 0);
    check("imem_ready",     bus.in_ready, 1);

    // DMEM: base 1, two doublewords
    s2 = log2.size();
    send(32'h4001_0002, 0);
    send(32'h1111_1111, 0);
    send(32'h2222_2222, 0);
    send(32'h3333_3333, 0);
    send(32'h4444_4444, 0);
    idle(3);
    #1;
    check("dmem_count", 64'(log2.size() - s2), 2);
    if (log2.size() - s2 == 2) begin
      check("dmem_a0", log2[s2].addr, 8);
      check("dmem_d0", log2[s2].data, 64'h2222_2222_1111_1111);
      check("dmem_a1", log2[s2+1].addr, 16);
      check("dmem_d1", log2[s2+1].data, 64'h4444_4444_3333_3333);
    end

    // START, ignored stream words while running, then halt
    send(32'h8000_0000, 0);
    check("start_enable", bus.cpu_enable, 1);
    check("start_ready",  bus.in_ready, 0);
    bus.in_data = 32'h0000_0001;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    bus.halt = 1'b1;
    @(negedge clk);
    bus.halt = 1'b0;
    check("halt_enable", bus.cpu_enable, 0);
    check("halt_ready",  bus.in_ready, 1);

    // Zero-count load writes nothing
    s1 = log1.size();
    send(32'h0005_0000, 0);
    idle(2);
    #1;
    check("zero_nowrite", 64'(log1.size() - s1), 0);
    check("zero_ready",   bus.in_ready, 1);
    check("zero_busy",    bus.busy, 0);

    // Reset after one of four IMEM words
    send(32'h0000_0004, 0);
    send(32'h1234_5678, 0);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_wen",   bus.wen_ext, 0);
    check("mid_rst_addr",  bus.addr_ext, 0);
    check("mid_rst_wdata", bus.wdata_ext, 0);
    check("mid_rst_busy",  bus.busy, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    rst = 1'b0;

    // Fresh header with random stalls: addresses strictly in order, no duplicates
    s1 = log1.size();
    send(32'h0010_0005, 1);
    for (int i = 0; i < 5; i++) send($urandom, 1);
    idle(3);
    #1;
    check("stall_count", 64'(log1.size() - s1), 5);
    if (log1.size() - s1 == 5)
      for (int i = 0; i < 5; i++) check("stall_addr", log1[s1+i].addr, 64'((16 + i) * 4));

    // Randomized command stream
    for (int n = 0; n < 40; n++) begin
      int kind = $urandom_range(0, 9);
      int cnt  = $urandom_range(0, 5);
      logic [13:0] b = 14'($urandom);
      if (kind < 4) begin
        send({2'b00, b, 16'(cnt)}, 1);
        for (int i = 0; i < cnt; i++) send($urandom, 1);
      end else if (kind < 8) begin
        send({2'b01, b, 16'(cnt)}, 1);
        for (int i = 0; i < 2 * cnt; i++) send($urandom, 1);
      end else begin
        send(32'h8000_0000 | 32'($urandom_range(0, 32'h3FFF_FFFF)), 1);
        repeat ($urandom_range(1, 4)) begin
          bus.in_valid = 1'($urandom_range(0, 1));
          bus.in_data  = $urandom;
          @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.halt = 1'b1;
        @(negedge clk);
        bus.halt = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    // Reserved command latches error until reset
    send(32'hC000_0000, 0);
    bus.in_data = 32'h0001_0001;
    repeat (4) @(negedge clk);
    check("err_flag",  bus.error, 1);
    check("err_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("err_cleared", bus.error, 0);
    check("err_ready_back", bus.in_ready, 1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the `cpu` top level and drives its external memory ports. It accepts a 32-bit word stream over a valid/ready handshake and decodes command headers. It writes instruction words into instruction memory and 64-bit data words into data memory, then raises the CPU `enable` on a start command. It owns `enable` for the whole run and drops it on `halt`.

## Interface
- `CNT_W`, default 16: width of the payload count field and the internal word counter.
- `BASE_W`, default 14: width of the base word-index field in a header.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset is synchronous and active-high; sampled on the rising edge of `clk`.
- `in_valid` input 1: stream word valid.
- `in_data` input 32: stream word.
- `in_ready` output 1: the loader can accept `in_data` this cycle.
- `halt` input 1: request to stop the CPU; honoured only in RUN.
- `addr_ext` output 64: instruction-memory byte address.
- `wen_ext` output 1: instruction-memory write strobe.
- `wdata_ext` output 32: instruction word.
- `addr_ext_2` output 64: data-memory byte address.
- `wen_ext_2` output 1: data-memory write strobe.
- `wdata_ext_2` output 64: data doubleword.
- `cpu_enable` output 1: drives the `cpu` `enable` input.
- `busy` output 1: high while a payload is in progress (IMEM, DLO, DHI).
- `error` output 1: sticky error flag.

## Operation
- **Handshake.** A word is accepted on a cycle where `in_valid && in_ready`. `in_ready` is 1 in HDR, IMEM, DLO and DHI, and 0 in RUN and ERR. `in_ready` is a function of state only, never of `in_valid`.
- **Header word layout.** `[31:30]` is `cmd`, `[29:16]` is `base`, `[15:0]` is `count`.
- **`cmd` values:**
  - 00: load IMEM with `count` words.
  - 01: load DMEM with `count` doublewords.
  - 10: START.
  - 11: reserved, which is an error.
- **States:**
  - HDR (after reset): on an accepted header, decode `cmd`.
    - `cmd` 00 goes to IMEM; `cmd` 01 goes to DLO.
    - If `count` is 0 on a load, stay in HDR and write nothing.
    - START goes to RUN. Reserved goes to ERR.
  - IMEM: each accepted word is written to instruction memory at `addr = (base + idx) << 2`.
  - DLO: the accepted word is latched as the low half, then go to DHI.
  - DHI: the accepted word forms `wdata_ext_2 = {word, low}`, written at `addr = (base + idx) << 3`, then go back to DLO.
  - Load exit: after the write with `idx == count-1`, return to HDR.
  - RUN: `cpu_enable` = 1. `halt` = 1 returns to HDR with `cpu_enable` = 0.
  - ERR: `error` = 1 and `in_ready` = 0. ERR is left only by reset.
- **Index counter.** `idx` is a `CNT_W`-bit counter, cleared on header accept and incremented once per memory write.
- **Address arithmetic.** `base + idx` is computed at `max(BASE_W, CNT_W)+1` bits with no wrap, shifted, and zero-extended to 64 bits.
- **Data capture.** `in_data` bits `[29:16]` are captured into `base` only at header accept. Payload words are never decoded as headers.
- **Reset mid-load.** All state returns to HDR on the next edge. Memory writes already made are not undone, and the partial load is simply abandoned.

## Timing
- **Reset values.** All outputs are 0 after reset, except `in_ready`, which is 1 (HDR). `wdata*` and `addr*` are also 0.
- **Output registering.** Memory-port outputs are registered.
  - For a payload accepted at edge N, `wen_ext` or `wen_ext_2` is high for exactly the cycle following edge N.
  - Address and data are valid in that same cycle.
  - Strobes are single-cycle pulses.
- **Throughput.** One word per cycle with no bubbles, so back-to-back IMEM writes appear on consecutive cycles. DMEM produces one write per two accepted words.
- **START timing.** `cpu_enable` rises in the cycle after START is accepted. It falls in the cycle after `halt` is sampled high in RUN.
- **Ignored `halt`.** `halt` outside RUN has no effect.
- **Simultaneous events.** `rst` has priority over everything. In RUN, `in_valid` is ignored because `in_ready` = 0.
- **Final-write timing.** The last payload write and the return to HDR happen together. A header word presented in the very next cycle is accepted.
- **`busy` timing.** `busy` follows state; it is 0 in the cycle in which the final strobe is high.

## Test plan
- **IMEM load.** Reset, send header 0x0002_0003 then words A, B, C back-to-back. Required: `wen_ext` is high for 3 consecutive cycles with `addr_ext` = 8, 12, 16 and `wdata_ext` = A, B, C. `busy` then drops and `in_ready` stays 1.
- **DMEM load.** Send header 0x4001_0002 then 0x11111111, 0x22222222, 0x33333333, 0x44444444. Required: 2 pulses on `wen_ext_2`:
  - `addr_ext_2` = 8 with `wdata_ext_2` = 0x22222222_11111111;
  - `addr_ext_2` = 16 with `wdata_ext_2` = 0x44444444_33333333.
- **Start and halt.** Send 0x8000_0000. Required: `cpu_enable` = 1 the next cycle and `in_ready` = 0 while in RUN. Pulse `halt`. Required: `cpu_enable` = 0 the next cycle and `in_ready` = 1.
- **Zero count and error.** Send 0x0005_0000. Required: no write and the loader stays in HDR. Send 0xC000_0000. Required: `error` = 1 and `in_ready` = 0, both held until `rst`.
- **Reset mid-load and stalls.** Reset after 1 of 4 IMEM words. Required: all outputs are at their reset values the next cycle, and a fresh header is accepted. Also toggle `in_valid` randomly during a load. Required: writes occur only on accepted words, with addresses in order and no duplicates.
